if_id_buffer: RTL and testbench

//  Fetch-to-decode pipeline stage, directly downstream of the 64-bit PC register.

---
 rtl/ifid_pkg.sv | 16 +
 rtl/ifid_if.sv | 25 ++
 rtl/ifid_slot.sv | 18 +
 rtl/if_id_buffer.sv | 93 +++++++++
 tb/tb_if_id_buffer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/ifid_pkg.sv
// Shared widths, packet type and state encoding for the fetch-to-decode buffer.
// NOP_INSTR is what decode sees whenever no packet is held.
package ifid_pkg;
    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} ifid_state_t;
endpackage

// File: rtl/ifid_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID buffer.
// slave = the buffer itself, master = fetch/decode environment.
interface ifid_if;
    import ifid_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    pc_out;
    logic [PC_W-1:0]    pc_plus4_out;
    logic [INSTR_W-1:0] instr_out;

    modport slave (
        input  in_valid, pc_in, instr_in, out_ready,
        output in_ready, out_valid, pc_out, pc_plus4_out, instr_out
    );

    modport master (
        output in_valid, pc_in, instr_in, out_ready,
        input  in_ready, out_valid, pc_out, pc_plus4_out, instr_out
    );
endinterface

// File: rtl/ifid_slot.sv
// One fetch packet register with load enable; sync active-low clear to zero.
// Latency 1 cycle from load to q; no flow control of its own.
module ifid_slot
    import ifid_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       ld,
    input  fetch_pkt_t d,
    output fetch_pkt_t q
);
    always_ff @(posedge clk) begin
        if (!reset)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/if_id_buffer.sv
// IF/ID stage: 2-entry skid buffer of {pc, instr}, 1-cycle latency, registered in_ready
// (low only when both slots held); flush empties it. Optional perf counters: IFID_PERF_CNT_EN.
module if_id_buffer
    import ifid_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    flush,
    ifid_if.slave   bus
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    ifid_state_t state, state_d;
    logic        in_ready_q;
    logic        out_valid;
    logic        push, pop;
    logic        main_ld, skid_ld;
    fetch_pkt_t  in_pkt, main_d, main_q, skid_q;

    assign in_pkt.pc    = bus.pc_in;
    assign in_pkt.instr = bus.instr_in;
    assign out_valid    = (state != EMPTY);

    always_comb begin
        push    = bus.in_valid & in_ready_q;
        pop     = out_valid & bus.out_ready;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_pkt;
        state_d = state;
        // Flush loads nothing so pc_out keeps the last held value.
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    main_ld = 1'b1;
                    state_d = ONE;
                end
                ONE: if (push && pop) begin
                    main_ld = 1'b1;
                end else if (push) begin
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (pop) begin
                    state_d = EMPTY;
                end
                FULL: if (pop) begin
                    main_ld = 1'b1;
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    ifid_slot u_main (.clk(clk), .reset(reset), .ld(main_ld), .d(main_d), .q(main_q));
    ifid_slot u_skid (.clk(clk), .reset(reset), .ld(skid_ld), .d(in_pkt), .q(skid_q));

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid;
    assign bus.pc_out       = main_q.pc;
    assign bus.pc_plus4_out = main_q.pc + PC_W'(4);
    assign bus.instr_out    = out_valid ? main_q.instr : NOP_INSTR;

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !bus.out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && out_valid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed vector bench for if_id_buffer: table of per-cycle stimulus and expected outputs,
// plus a hand-written reset-during-stall sequence (and counter checks in the perf build).
module tb_if_id_buffer;
    import ifid_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    ifid_if bus();
`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    if_id_buffer dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        e_ov;
        logic        e_ir;
        logic [63:0] e_pc;
        logic [63:0] e_pp4;
        logic [31:0] e_ins;
    } vec_t;

    localparam logic [31:0] NOP = 32'hD503201F;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [63:0] pc, input logic [31:0] ins);
        reset         = rst;
        flush         = fl;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        bus.pc_in     = pc;
        bus.instr_in  = ins;
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic ir,
                            input logic [63:0] pc, input logic [63:0] pp4, input logic [31:0] ins);
        chk({tag, " out_valid"},    64'(bus.out_valid),    64'(ov));
        chk({tag, " in_ready"},     64'(bus.in_ready),     64'(ir));
        chk({tag, " pc_out"},       bus.pc_out,            pc);
        chk({tag, " pc_plus4_out"}, bus.pc_plus4_out,      pp4);
        chk({tag, " instr_out"},    64'(bus.instr_out),    64'(ins));
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);

        // rst fl iv ordy pc ins | ov ir pc pp4 ins
        // Reset values
        vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b0, 1'b1, 64'h0,   64'h4,   NOP});
        // Streaming with decode always ready
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 64'h0,   32'h8B020020, 1'b1, 1'b1, 64'h0,   64'h4,   32'h8B020020});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 64'h4,   32'h8B020021, 1'b1, 1'b1, 64'h4,   64'h8,   32'h8B020021});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 64'h8,   32'h8B020022, 1'b1, 1'b1, 64'h8,   64'hC,   32'h8B020022});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b0, 1'b1, 64'h8,   64'hC,   NOP});
        // Back-pressure fills skid, then drain in order
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'h100, 32'hAA000100, 1'b1, 1'b1, 64'h100, 64'h104, 32'hAA000100});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'h104, 32'hAA000104, 1'b1, 1'b0, 64'h100, 64'h104, 32'hAA000100});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'h108, 32'hAA000108, 1'b1, 1'b0, 64'h100, 64'h104, 32'hAA000100});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b1, 1'b1, 64'h104, 64'h108, 32'hAA000104});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b0, 1'b1, 64'h104, 64'h108, NOP});
        // Flush while FULL with a packet offered
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'h300, 32'hBB000300, 1'b1, 1'b1, 64'h300, 64'h304, 32'hBB000300});
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'h304, 32'hBB000304, 1'b1, 1'b0, 64'h300, 64'h304, 32'hBB000300});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 64'h200, 32'hCC000200, 1'b0, 1'b1, 64'h300, 64'h304, NOP});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b0, 1'b1, 64'h300, 64'h304, NOP});
        // Flush while ONE drops a packet that in_ready would have accepted
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 64'h400, 32'hDD000400, 1'b1, 1'b1, 64'h400, 64'h404, 32'hDD000400});
        vq.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 64'h404, 32'hDD000404, 1'b0, 1'b1, 64'h400, 64'h404, NOP});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b0, 1'b1, 64'h400, 64'h404, NOP});
        // pc+4 wrap, held stable under stall
        vq.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFC, 32'hEE0000FC, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h0, 32'hEE0000FC});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   32'h0,        1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h0, 32'hEE0000FC});
        vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 64'h0,   32'h0,        1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h0, NOP});

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].pc, vq[i].ins);
            tick();
            chk_outs($sformatf("v%0d", i), vq[i].e_ov, vq[i].e_ir, vq[i].e_pc, vq[i].e_pp4, vq[i].e_ins);
        end

        // Reset while FULL and stalled, with a packet offered at the same edge
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h500, 32'hF0000500);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h504, 32'hF0000504);
        tick();
        chk_outs("full_before_reset", 1'b1, 1'b0, 64'h500, 64'h504, 32'hF0000500);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
        tick();
        tick();
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
        chk("flush_cnt_0", 64'(flush_cnt), 64'd0);
        // Flush in FULL: counts one flush and one more stall, counters survive flush
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0);
        tick();
        chk("stall_cnt_4", 64'(stall_cnt), 64'd4);
        chk("flush_cnt_1", 64'(flush_cnt), 64'd1);
        // Flush while EMPTY is not counted
        tick();
        chk("flush_cnt_empty", 64'(flush_cnt), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h600, 32'hF0000600);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 64'h604, 32'hF0000604);
        tick();
        chk_outs("refill_full", 1'b1, 1'b0, 64'h600, 64'h604, 32'hF0000600);
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h700, 32'hF0000700);
        tick();
        chk_outs("reset_mid_stall", 1'b0, 1'b1, 64'h0, 64'h4, NOP);
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt_reset", 64'(stall_cnt), 64'd0);
        chk("flush_cnt_reset", 64'(flush_cnt), 64'd0);
`endif
        // First packet after reset appears one cycle later
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h800, 32'h12345678);
        tick();
        chk_outs("post_reset_push", 1'b1, 1'b1, 64'h800, 64'h804, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
